// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Shares one combinational ALU among NREQ issue lanes. Lanes are picked
//   round-robin. The winner is latched into an issue register (S1), which
//   drives the ALU select lines and operands. The ALU result is then latched
//   into a response register (S2), which also carries the winning lane ID and
//   the request tag.
//
// Ports
//   clk, reset            : clock and synchronous active-high reset
//   io_req_valid/ready    : per-lane request handshake (ready is one-hot or zero)
//   io_req_op/a/b/tag     : per-lane opcode (5b), operands (W), tag (TAGW)
//   io_flush              : drops everything in flight, blocks accept this cycle
//   io_alu_sel            : one-hot ALU select (all-zero for op >= 21, i.e. XOR)
//   io_alu1/io_alu2       : ALU operands
//   io_alu_out            : combinational ALU result
//   io_resp_valid/ready   : response handshake
//   io_resp_data/id/tag   : result, winning lane index, echoed tag
//   io_op_count           : completed-response counter (wraps)
module alu_share_arbiter #(
   parameter int NREQ = 4,
   parameter int W    = 64,
   parameter int TAGW = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NREQ-1:0]      io_req_valid,
   output logic [NREQ-1:0]      io_req_ready,
   input  logic [NREQ*5-1:0]    io_req_op,
   input  logic [NREQ*W-1:0]    io_req_a,
   input  logic [NREQ*W-1:0]    io_req_b,
   input  logic [NREQ*TAGW-1:0] io_req_tag,
   input  logic                 io_flush,
   output logic [20:0]          io_alu_sel,
   output logic [W-1:0]         io_alu1,
   output logic [W-1:0]         io_alu2,
   input  logic [W-1:0]         io_alu_out,
   output logic                 io_resp_valid,
   input  logic                 io_resp_ready,
   output logic [W-1:0]         io_resp_data,
   output logic [2:0]           io_resp_id,
   output logic [TAGW-1:0]      io_resp_tag,
   output logic [31:0]          io_op_count
);

   // (base + k) mod NREQ, for base < NREQ and k < NREQ
   function automatic logic [2:0] wrap_add(input logic [2:0] base, input int k);
      int s;
      s = int'(base) + k;
      if (s >= NREQ) begin
         s = s - NREQ;
      end else begin
         s = s;
      end
      return 3'(s);
   endfunction

   // Opcodes 21..31 give an all-zero select, and the ALU then defaults to XOR
   function automatic logic [20:0] decode_op(input logic [4:0] op);
      logic [20:0] sel;
      if (op < 5'd21) begin
         sel = 21'd1 << op;
      end else begin
         sel = 21'd0;
      end
      return sel;
   endfunction

   logic [2:0]      rr_ptr_r;
   logic            s1_valid_r;
   logic [20:0]     alu_sel_r;
   logic [W-1:0]    alu1_r;
   logic [W-1:0]    alu2_r;
   logic [2:0]      s1_id_r;
   logic [TAGW-1:0] s1_tag_r;
   logic            s2_valid_r;
   logic [W-1:0]    s2_data_r;
   logic [2:0]      s2_id_r;
   logic [TAGW-1:0] s2_tag_r;
   logic [31:0]     op_count_r;

   logic [7:0]      valid_ext_s;
   logic [7:0]      grant_s;
   logic [2:0]      cand_s;
   logic [2:0]      winner_s;
   logic            found_s;
   logic            s2_free_s;
   logic            s1_free_s;
   logic            s1_adv_s;
   logic            accept_s;
   logic            resp_fire_s;

   assign valid_ext_s = 8'(io_req_valid);
   assign s2_free_s   = !s2_valid_r || io_resp_ready;
   assign s1_free_s   = !s1_valid_r || s2_free_s;
   assign s1_adv_s    = s1_valid_r && s2_free_s;
   assign resp_fire_s = s2_valid_r && io_resp_ready;

   // Round-robin search: first valid lane at or after rr_ptr, wrapping
   always_comb begin
      found_s  = 1'b0;
      winner_s = 3'd0;
      cand_s   = 3'd0;
      for (int k = 0; k < NREQ; k++) begin
         cand_s = wrap_add(rr_ptr_r, k);
         if (!found_s && valid_ext_s[cand_s]) begin
            found_s  = 1'b1;
            winner_s = cand_s;
         end else begin
            found_s  = found_s;
         end
      end
   end

   // Grant only when S1 can take a new entry; flush and reset block accept
   always_comb begin
      accept_s = found_s && s1_free_s && !io_flush && !reset;
      if (accept_s) begin
         grant_s = 8'd1 << winner_s;
      end else begin
         grant_s = 8'd0;
      end
   end

   assign io_req_ready = grant_s[NREQ-1:0];

   // Round-robin pointer moves past the winner on every accept
   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr_r <= 3'd0;
      end else if (accept_s) begin
         rr_ptr_r <= wrap_add(winner_s, 1);
      end else begin
         rr_ptr_r <= rr_ptr_r;
      end
   end

   // S1 issue register; operands keep their last value when S1 empties
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid_r <= 1'b0;
         alu_sel_r  <= 21'd0;
         alu1_r     <= '0;
         alu2_r     <= '0;
         s1_id_r    <= 3'd0;
         s1_tag_r   <= '0;
      end else if (io_flush) begin
         s1_valid_r <= 1'b0;
         alu_sel_r  <= 21'd0;
      end else if (accept_s) begin
         s1_valid_r <= 1'b1;
         alu_sel_r  <= decode_op(io_req_op[int'(winner_s)*5 +: 5]);
         alu1_r     <= io_req_a[int'(winner_s)*W +: W];
         alu2_r     <= io_req_b[int'(winner_s)*W +: W];
         s1_id_r    <= winner_s;
         s1_tag_r   <= io_req_tag[int'(winner_s)*TAGW +: TAGW];
      end else if (s1_adv_s) begin
         s1_valid_r <= 1'b0;
         alu_sel_r  <= 21'd0;
      end else begin
         s1_valid_r <= s1_valid_r;
      end
   end

   // S2 response register; captures the ALU result as S1 advances
   always_ff @(posedge clk) begin
      if (reset) begin
         s2_valid_r <= 1'b0;
         s2_data_r  <= '0;
         s2_id_r    <= 3'd0;
         s2_tag_r   <= '0;
      end else if (io_flush) begin
         s2_valid_r <= 1'b0;
      end else if (s1_adv_s) begin
         s2_valid_r <= 1'b1;
         s2_data_r  <= io_alu_out;
         s2_id_r    <= s1_id_r;
         s2_tag_r   <= s1_tag_r;
      end else if (io_resp_ready) begin
         s2_valid_r <= 1'b0;
      end else begin
         s2_valid_r <= s2_valid_r;
      end
   end

   // Completed-response counter; a handshake in a flush cycle still counts
   always_ff @(posedge clk) begin
      if (reset) begin
         op_count_r <= 32'd0;
      end else if (resp_fire_s) begin
         op_count_r <= op_count_r + 32'd1;
      end else begin
         op_count_r <= op_count_r;
      end
   end

   assign io_alu_sel    = alu_sel_r;
   assign io_alu1       = alu1_r;
   assign io_alu2       = alu2_r;
   assign io_resp_valid = s2_valid_r;
   assign io_resp_data  = s2_data_r;
   assign io_resp_id    = s2_id_r;
   assign io_resp_tag   = s2_tag_r;
   assign io_op_count   = op_count_r;

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Round-robin arbiter and two-stage issue pipeline that shares one combinational 64-bit ALU between `NREQ` VLIW issue lanes. It accepts operation requests over valid/ready handshakes, drives the ALU's one-hot select lines and operands from a register stage, and captures the ALU result into a response register that carries the winning lane ID and a tag. The block sits between the lane decoders and the shared non-multiplying ALU.

## Interface
- `NREQ`, 4: number of requesting lanes (2..8).
- `W`, 64: operand and result width.
- `TAGW`, 4: width of the opaque request tag.
- `clk` in 1: single clock. All state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `io_req_valid` in NREQ: per-lane request valid.
- `io_req_ready` out NREQ: per-lane accept. At most one bit high per cycle.
- `io_req_op` in NREQ*5: per-lane opcode (select index 0..20). Lane i uses bits [5i+4:5i].
- `io_req_a`, `io_req_b` in NREQ*W: per-lane operands, lane i uses [W*i+W-1:W*i].
- `io_req_tag` in NREQ*TAGW: per-lane tag.
- `io_flush` in 1: synchronous pipeline flush.
- `io_alu_sel` out 21: one-hot select to the ALU (`io_sel_0`..`io_sel_20`).
- `io_alu1`, `io_alu2` out W: ALU operands.
- `io_alu_out` in W: combinational ALU result.
- `io_resp_valid` out 1, `io_resp_ready` in 1: response handshake.
- `io_resp_data` out W, `io_resp_id` out 3, `io_resp_tag` out TAGW: result, winning lane index, echoed tag.
- `io_op_count` out 32: completed-response counter.

## Operation
- Arbitration: round-robin over lanes with `io_req_valid` high. The search starts at `rr_ptr` and wraps modulo NREQ. The winner gets `io_req_ready` only when `s1_free = !s1_valid | s2_free`, where `s2_free = !s2_valid | io_resp_ready`. If `io_flush` is high, all `io_req_ready` bits are 0.
- `rr_ptr` resets to 0. On each accepted handshake it becomes (winner+1) mod NREQ. It is unchanged when nothing is accepted.
- S1 (issue register), loaded on accept:
  - `s1_valid` is set to 1.
  - `io_alu_sel` = 1<<op for op 0..20. For op 21..31 it is all zeros, and the ALU then produces XOR.
  - `io_alu1`/`io_alu2` take the lane's a/b. The lane ID and tag are also stored.
- If S1 advances and there is no new accept, `s1_valid` drops to 0 and `io_alu_sel` is cleared to 0. Operands hold their last value.
- S2 (response register): when `s1_valid && s2_free`, it captures `io_alu_out`, the S1 ID and the S1 tag, and sets `s2_valid` (`io_resp_valid`).
- S2 clears when `io_resp_ready` is high and no new S1 data arrives.
- Back-pressure: while `s2_valid && !io_resp_ready`, S2 holds. S1 holds if it is valid. Acceptance stalls only if both stages are occupied.
- `io_op_count` increments by 1 on each `io_resp_valid && io_resp_ready`. It wraps from 0xFFFFFFFF to 0.
- Flush:
  - Clears `s1_valid` and `s2_valid`, and sets `io_alu_sel` to 0.
  - Blocks acceptance that cycle.
  - `rr_ptr` and `io_op_count` are unchanged, except that a response handshake completing in the flush cycle still counts.
- Reset values: `io_req_ready` = 0 during reset. All of the following are 0: `io_alu_sel`, `io_alu1`, `io_alu2`, `io_resp_valid`, `io_resp_data`, `io_resp_id`, `io_resp_tag`, `io_op_count`, `rr_ptr`.

## Timing
- Accept in cycle t, meaning `io_req_valid & io_req_ready` is sampled at the edge ending cycle t.
- `io_alu_sel`/`io_alu1`/`io_alu2` are valid in cycle t+1.
- `io_resp_valid` and data are valid in cycle t+2.
- Throughput is one operation per cycle with `io_resp_ready` held high.
- `io_req_ready` is combinational from `io_req_valid`, `rr_ptr`, pipeline state, `io_resp_ready` and `io_flush`. There is no combinational path from `io_alu_out` to any output.
- A requester holds valid, op, operands and tag stable until accepted. The block never drops an accepted request except on flush or reset.
- Reset mid-operation discards both stages within the reset cycle. Reset has priority over flush.

## Test plan
- Single op: lane 2 requests op 0 with a=5, b=7, all other lanes idle, `io_resp_ready`=1 -> `io_req_ready`[2] high at t. `io_alu_sel`=0x000001 at t+1. Response at t+2 with data=12, id=2, and `io_op_count`=1.
- Round-robin: all 4 lanes valid continuously with op 1, a=10, b=lane -> grants follow order 0,1,2,3,0. Responses arrive back to back with data 10,9,8,7,10.
- Back-pressure: stream from lane 0 with `io_resp_ready`=0 for 5 cycles -> exactly 2 accepts, then `io_req_ready`=0. S2 holds the first result unchanged. Releasing `io_resp_ready` gives in-order responses with none lost.
- Opcode map: op 6, 7, 8 and 25 with a=0xF0F0, b=0xFF00 -> data 0xF000, 0xFFF0, 0xFFFFFFFFFFFF0FFF, 0x0FF0 (all-zero select, so XOR).
- Flush: 2 ops in flight, assert `io_flush` one cycle -> no response appears. `io_req_ready`=0 in that cycle. `rr_ptr` is preserved, so the next grant is to the lane after the last winner.
- Wrap and reset: force `io_op_count` to 0xFFFFFFFF, complete one op -> count is 0. Assert `reset` with an op in S1 -> `io_resp_valid` stays 0 and all outputs are 0 the next cycle.
